// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
// Optional per-channel beat counters are enabled with DEMUX_1_N_STREAM_CNT_EN.
package demux_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_N_OUT  = 2;
   localparam int CNT_W          = 16;

   // A slot is either holding a beat for its downstream or not.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for a single output channel.
// The write side is only enabled by the parent when the slot can take a beat,
// so a write always lands either in an empty slot or in one being drained.
// With DEMUX_1_N_STREAM_CNT_EN defined, also counts output handshakes.
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_ready,
   output slot_state_t       state_o,
   output logic [DATA_W-1:0] data_o
`ifdef DEMUX_1_N_STREAM_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_o
`endif
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              drain;

   assign drain = (state_q == SLOT_FULL) && rd_ready;

   // Next slot state: a write wins over a drain so a same-cycle refill keeps the slot full.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (wr_en) begin
         state_d = SLOT_FULL;
         data_d  = wr_data;
      end else if (drain) begin
         state_d = SLOT_EMPTY;
      end
   end

   // Slot registers; reset drops any held beat immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign state_o = state_q;
   assign data_o  = data_q;

`ifdef DEMUX_1_N_STREAM_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Handshake count, wrapping naturally at the counter width.
   always_comb begin
      cnt_d = cnt_q;
      if (drain) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N stream demultiplexer. One input stream is steered to the
// output channel named by in_sel; each channel has its own one-entry slot so a
// stalled channel never blocks or corrupts another.
// Handshake: a beat moves on a side when valid && ready at a rising clk edge;
// valid never waits on ready, and in_ready does not look at in_valid.
// Out-of-range selects are accepted and discarded, raising sticky sel_err.
// Optional per-channel handshake counters: DEMUX_1_N_STREAM_CNT_EN.
module demux_1_n_stream
   import demux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int N_OUT  = DEFAULT_N_OUT,
   parameter int SEL_W  = $clog2(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic                    sel_err
`ifdef DEMUX_1_N_STREAM_CNT_EN
   ,
   output logic [N_OUT*CNT_W-1:0]  beat_cnt
`endif
);

   slot_state_t      slot_state [N_OUT];
   logic             sel_legal;
   logic [N_OUT-1:0] wr_en;
   logic             sel_err_q, sel_err_d;

   // Ready for the addressed slot; an illegal select is always swallowed.
   always_comb begin
      sel_legal = 1'b0;
      in_ready  = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_legal = 1'b1;
            in_ready  = !out_valid[k] || out_ready[k];
         end
      end
      if (!sel_legal) begin
         in_ready = 1'b1;
      end
      if (rst) begin
         in_ready = 1'b0;
      end
   end

   // Select decode: only the addressed slot sees a write on an accept.
   always_comb begin
      wr_en = '0;
      for (int k = 0; k < N_OUT; k++) begin
         wr_en[k] = in_valid && in_ready && (in_sel == SEL_W'(k));
      end
   end

   // Sticky illegal-select flag, cleared only by reset.
   always_comb begin
      sel_err_d = sel_err_q | (in_valid && in_ready && !sel_legal);
   end

   // Error flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en[k]),
         .wr_data  (in_data),
         .rd_ready (out_ready[k]),
         .state_o  (slot_state[k]),
         .data_o   (out_data[k*DATA_W +: DATA_W])
`ifdef DEMUX_1_N_STREAM_CNT_EN
         ,
         .cnt_o    (beat_cnt[k*CNT_W +: CNT_W])
`endif
      );

      assign out_valid[k] = (slot_state[k] == SLOT_FULL);
   end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed bench for demux_1_n_stream, built with three output channels so
// that select value 3 is out of range.
module tb_demux_1_n_stream;

   localparam int DW = 8;
   localparam int NO = 3;
   localparam int SW = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic [SW-1:0]    in_sel;
   logic [NO-1:0]    out_valid;
   logic [NO-1:0]    out_ready;
   logic [NO*DW-1:0] out_data;
   logic             sel_err;
`ifdef DEMUX_1_N_STREAM_CNT_EN
   logic [NO*16-1:0] beat_cnt;
`endif

   int errors = 0;
   int checks = 0;

   demux_1_n_stream #(
      .DATA_W (DW),
      .N_OUT  (NO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_err   (sel_err)
`ifdef DEMUX_1_N_STREAM_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard model ----------------
   // Each channel is a FIFO of beats accepted but not yet handed downstream.
   logic [DW-1:0] exp_q [NO][$];
   logic          exp_err;
   int            hs_cnt [NO];

   // Checks on the falling edge, then advances the model by the coming rising edge.
   always @(negedge clk) begin
      logic exp_rdy;
      int   s;
      if (rst) begin
         for (int k = 0; k < NO; k++) begin
            exp_q[k].delete();
            hs_cnt[k] = 0;
         end
         exp_err = 1'b0;
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_sel_err", 32'(sel_err), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd0);
      end else begin
         s = int'(in_sel);
         if (s >= NO) exp_rdy = 1'b1;
         else         exp_rdy = (exp_q[s].size() == 0) || out_ready[s];
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("sel_err", 32'(sel_err), 32'(exp_err));
         for (int k = 0; k < NO; k++) begin
            chk("out_valid", 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
            if (exp_q[k].size() != 0)
               chk("out_data", 32'(out_data[k*DW +: DW]), 32'(exp_q[k][0]));
`ifdef DEMUX_1_N_STREAM_CNT_EN
            chk("beat_cnt", 32'(beat_cnt[k*16 +: 16]), hs_cnt[k] & 32'hFFFF);
`endif
         end
         for (int k = 0; k < NO; k++) begin
            if (exp_q[k].size() != 0 && out_ready[k]) begin
               void'(exp_q[k].pop_front());
               hs_cnt[k]++;
            end
         end
         if (in_valid && exp_rdy) begin
            if (s >= NO) exp_err = 1'b1;
            else         exp_q[s].push_back(in_data);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
      logic          vld;
      logic [NO-1:0] rdy;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{2'd2, 8'h10, 1'b1, 3'b000};
      tbl[1]  = '{2'd2, 8'h11, 1'b1, 3'b000};
      tbl[2]  = '{2'd0, 8'h12, 1'b1, 3'b000};
      tbl[3]  = '{2'd1, 8'h13, 1'b1, 3'b001};
      tbl[4]  = '{2'd2, 8'h14, 1'b1, 3'b100};
      tbl[5]  = '{2'd3, 8'h15, 1'b1, 3'b000};
      tbl[6]  = '{2'd0, 8'h16, 1'b0, 3'b111};
      tbl[7]  = '{2'd1, 8'h17, 1'b1, 3'b010};
      tbl[8]  = '{2'd1, 8'h18, 1'b1, 3'b010};
      tbl[9]  = '{2'd0, 8'h19, 1'b1, 3'b000};
      tbl[10] = '{2'd0, 8'h1A, 1'b1, 3'b000};
      tbl[11] = '{2'd2, 8'h1B, 1'b1, 3'b011};

      rst = 1'b1;
      in_valid = 1'b0;
      in_sel = '0;
      in_data = '0;
      out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("lit_rst_valid", 32'(out_valid), 32'd0);
      chk("lit_rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;

      // basic steering
      out_ready = 3'b111;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hA5;
      #1 chk("lit_steer_rdy0", 32'(in_ready), 32'd1);
      tick();
      chk("lit_steer_v0", 32'(out_valid), 32'b001);
      chk("lit_steer_d0", 32'(out_data[7:0]), 32'hA5);
      in_sel = 2'd1; in_data = 8'h3C;
      #1 chk("lit_steer_rdy1", 32'(in_ready), 32'd1);
      tick();
      chk("lit_steer_v1", 32'(out_valid), 32'b010);
      chk("lit_steer_d1", 32'(out_data[15:8]), 32'h3C);
      in_valid = 1'b0;
      tick();
      chk("lit_steer_idle", 32'(out_valid), 32'd0);

      // stall isolation
      out_ready = 3'b010;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
      tick();
      chk("lit_stall_d11", 32'(out_data[7:0]), 32'h11);
      in_data = 8'h22;
      #1 chk("lit_stall_rdy0", 32'(in_ready), 32'd0);
      tick();
      chk("lit_stall_hold", 32'(out_data[7:0]), 32'h11);
      in_sel = 2'd1; in_data = 8'h33;
      #1 chk("lit_stall_rdy1", 32'(in_ready), 32'd1);
      tick();
      chk("lit_stall_v", 32'(out_valid), 32'b011);
      chk("lit_stall_d33", 32'(out_data[15:8]), 32'h33);
      out_ready = 3'b011; in_sel = 2'd0; in_data = 8'h22;
      #1 chk("lit_release_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("lit_release_v", 32'(out_valid), 32'b001);
      chk("lit_release_d22", 32'(out_data[7:0]), 32'h22);
      in_valid = 1'b0;
      tick();

      // simultaneous drain and write
      out_ready = 3'b000;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
      tick();
      out_ready = 3'b001; in_data = 8'h02;
      #1 chk("lit_dw_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("lit_dw_v", 32'(out_valid), 32'b001);
      chk("lit_dw_d02", 32'(out_data[7:0]), 32'h02);

      // illegal select
      out_ready = 3'b000; in_sel = 2'd3; in_data = 8'hFF;
      #1 chk("lit_ill_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("lit_ill_err", 32'(sel_err), 32'd1);
      chk("lit_ill_v", 32'(out_valid), 32'b001);
      chk("lit_ill_d", 32'(out_data[7:0]), 32'h02);
      in_valid = 1'b0; out_ready = 3'b111;
      repeat (2) tick();

      // mixed directed traffic, checked by the model
      for (int i = 0; i < 12; i++) begin
         in_sel = tbl[i].sel;
         in_data = tbl[i].data;
         in_valid = tbl[i].vld;
         out_ready = tbl[i].rdy;
         tick();
      end
      in_valid = 1'b0; out_ready = 3'b111;
      repeat (3) tick();

      // asynchronous reset with beats held
      out_ready = 3'b000;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
      tick();
      in_sel = 2'd1; in_data = 8'h6B;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("lit_arst_valid", 32'(out_valid), 32'd0);
      chk("lit_arst_data", 32'(out_data), 32'd0);
      chk("lit_arst_err", 32'(sel_err), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 3'b111;
      repeat (3) begin
         tick();
         chk("lit_post_rst_valid", 32'(out_valid), 32'd0);
      end

`ifdef DEMUX_1_N_STREAM_CNT_EN
      // counter wrap on channel 1
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
      repeat (65537) tick();
      in_valid = 1'b0;
      tick();
      chk("lit_cnt_ch1", 32'(beat_cnt[31:16]), 32'd1);
      chk("lit_cnt_ch0", 32'(beat_cnt[15:0]), 32'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
